tag_match_encoder: RTL and testbench

Per-set tag lookup unit for the set-associative L2 cache. Compares one lookup tag against the stored tags of all ways of the indexed set, qualifies each match with that way's valid (non-Invalid MESI) state, and priority-encodes the match vector into a way index plus hit and multi-hit flags. Sits between the tag storage read port and the L2 control logic, which uses `hit`/`hit_way` to select the line for read, write and LRU update.

---
 rtl/tag_match_encoder.sv | 68 ++++++
 tb/tb_tag_match_encoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tag_match_encoder.sv
// Per-set tag lookup: compares one lookup tag against every way's stored tag.
// Matches are qualified by the way's valid state, then priority-encoded into a registered hit/way/multi-hit result.
module tag_match_encoder #(
  parameter  int WAYS     = 8,
  parameter  int TAG_BITS = 12,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [TAG_BITS-1:0]      lookup_tag,
  input  logic [WAYS*TAG_BITS-1:0] way_tags,
  input  logic [WAYS-1:0]          way_valid,
  output logic                     out_valid,
  output logic [WAYS-1:0]          match_vec,
  output logic                     hit,
  output logic [WAY_BITS-1:0]      hit_way,
  output logic                     multi_hit
);

  logic [WAYS-1:0]     match_c;
  logic                hit_c;
  logic [WAY_BITS-1:0] hit_way_c;
  logic                multi_hit_c;

  // A way counts only when its full tag matches and its line is not Invalid.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < WAYS; i++) begin
      match_c[i] = (way_tags[i*TAG_BITS +: TAG_BITS] == lookup_tag) && way_valid[i];
    end
  end

  // NOTE: combinational blocks use blocking '=' with a default assigned first,
  // so every path writes the variable and no latch is inferred.
  always_comb begin
    hit_way_c = '0;
    // Scanning from the top down lets the lowest matching index win.
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match_c[i]) hit_way_c = WAY_BITS'(i);
    end
  end

  assign hit_c = |match_c;
  // Clearing the lowest set bit leaves something behind only when two or more bits were set.
  assign multi_hit_c = |(match_c & (match_c - WAYS'(1)));

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; reset here is synchronous and overrides a same-cycle request.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      match_vec <= '0;
      hit       <= 1'b0;
      hit_way   <= '0;
      multi_hit <= 1'b0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      match_vec <= match_c;
      hit       <= hit_c;
      hit_way   <= hit_way_c;
      multi_hit <= multi_hit_c;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tag_match_encoder.sv
// Self-checking bench for tag_match_encoder: directed cases plus randomized lookups
// compared against a list-of-hits reference model.
module tb_tag_match_encoder;

  localparam int WAYS     = 8;
  localparam int TAG_BITS = 12;
  localparam int WAY_BITS = 3;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic [TAG_BITS-1:0]      lookup_tag;
  logic [WAYS*TAG_BITS-1:0] way_tags;
  logic [WAYS-1:0]          way_valid;
  logic                     out_valid;
  logic [WAYS-1:0]          match_vec;
  logic                     hit;
  logic [WAY_BITS-1:0]      hit_way;
  logic                     multi_hit;

  tag_match_encoder #(.WAYS(WAYS), .TAG_BITS(TAG_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .lookup_tag (lookup_tag),
    .way_tags   (way_tags),
    .way_valid  (way_valid),
    .out_valid  (out_valid),
    .match_vec  (match_vec),
    .hit        (hit),
    .hit_way    (hit_way),
    .multi_hit  (multi_hit)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [TAG_BITS-1:0] tag_arr [WAYS];

  logic                exp_valid = 1'b0;
  logic [WAYS-1:0]     exp_match = '0;
  logic                exp_hit   = 1'b0;
  logic [WAY_BITS-1:0] exp_way   = '0;
  logic                exp_multi = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: collect the list of qualifying ways, then read the result off the list.
  task automatic model_lookup();
    int hits[$];
    hits = {};
    for (int i = 0; i < WAYS; i++) begin
      if (way_valid[i] === 1'b1 && tag_arr[i] == lookup_tag) hits.push_back(i);
    end
    exp_valid = 1'b1;
    exp_match = '0;
    foreach (hits[k]) exp_match[hits[k]] = 1'b1;
    exp_hit   = (hits.size() > 0);
    exp_way   = (hits.size() > 0) ? WAY_BITS'(hits[0]) : '0;
    exp_multi = (hits.size() >= 2);
  endtask

  // Applies the current inputs at one edge, then scrambles the data inputs
  // before checking so any non-registered path shows up.
  task automatic step(input string name);
    logic [TAG_BITS-1:0] save_tag;
    logic [WAYS-1:0]     save_valid;
    for (int i = 0; i < WAYS; i++) way_tags[i*TAG_BITS +: TAG_BITS] = tag_arr[i];
    if (reset) begin
      exp_valid = 1'b0; exp_match = '0; exp_hit = 1'b0; exp_way = '0; exp_multi = 1'b0;
    end else if (in_valid) begin
      model_lookup();
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    save_tag   = lookup_tag;
    save_valid = way_valid;
    lookup_tag = TAG_BITS'($urandom);
    way_tags   = {$urandom, $urandom, $urandom};
    way_valid  = WAYS'($urandom);
    #1;
    check({name, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    check({name, ".match_vec"}, 32'(match_vec), 32'(exp_match));
    check({name, ".hit"},       32'(hit),       32'(exp_hit));
    check({name, ".hit_way"},   32'(hit_way),   32'(exp_way));
    check({name, ".multi_hit"}, 32'(multi_hit), 32'(exp_multi));
    lookup_tag = save_tag;
    way_valid  = save_valid;
  endtask

  task automatic fill_distinct();
    for (int i = 0; i < WAYS; i++) tag_arr[i] = TAG_BITS'(12'h555 + i);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b1;
    lookup_tag = 12'hABC;
    way_valid  = 8'hFF;
    fill_distinct();
    tag_arr[5] = 12'hABC;

    // Reset held with a pending request: nothing must come out.
    for (int c = 0; c < 3; c++) step("reset_hold");
    reset    = 1'b0;
    in_valid = 1'b0;
    step("reset_release");

    // Single hit on way 5.
    in_valid = 1'b1;
    step("single_hit");
    check("single_hit.way5", 32'(hit_way), 32'd5);

    // Same tag but way 5 Invalid.
    way_valid = 8'hDF;
    step("invalid_gate");

    // Two matching ways: lowest index wins, multi-hit flagged.
    fill_distinct();
    tag_arr[2] = 12'h123; tag_arr[6] = 12'h123;
    lookup_tag = 12'h123; way_valid = 8'hFF;
    step("multi_hit");
    check("multi_hit.vec", 32'(match_vec), 32'h44);

    // Back-to-back: ways 0, 7, then a miss, then hold.
    fill_distinct();
    tag_arr[0] = 12'h0A0; tag_arr[7] = 12'h0B7;
    lookup_tag = 12'h0A0; step("b2b_way0");
    lookup_tag = 12'h0B7; step("b2b_way7");
    lookup_tag = 12'hEEE; step("b2b_miss");
    in_valid = 1'b0;
    step("hold1");
    step("hold2");

    // Boundary tags and an MSB-only difference.
    in_valid = 1'b1;
    fill_distinct();
    tag_arr[3] = 12'h000; tag_arr[4] = 12'hFFF;
    lookup_tag = 12'h000; step("bound_zero");
    check("bound_zero.way3", 32'(hit_way), 32'd3);
    lookup_tag = 12'hFFF; step("bound_ones");
    check("bound_ones.way4", 32'(hit_way), 32'd4);
    lookup_tag = 12'h7FF; step("bound_msb");
    check("bound_msb.miss", 32'(hit), 32'd0);

    // Reset while a result is presented clears it.
    lookup_tag = 12'hFFF; step("pre_reset_hit");
    reset = 1'b1; in_valid = 1'b0;
    step("reset_clear");
    reset = 1'b0;

    // Randomized lookups with biased tag collisions and occasional resets.
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 31) == 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      lookup_tag = TAG_BITS'($urandom);
      for (int i = 0; i < WAYS; i++) begin
        case ($urandom_range(0, 3))
          0:       tag_arr[i] = lookup_tag;
          1:       tag_arr[i] = lookup_tag ^ TAG_BITS'(1 << $urandom_range(0, TAG_BITS - 1));
          default: tag_arr[i] = TAG_BITS'($urandom);
        endcase
      end
      way_valid = WAYS'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
